// File: rtl/cpu_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath_pkg
// Description : Widths, depths and control encodings of the accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_datapath_pkg;

    localparam int c_data_w    = 8;
    localparam int c_rf_depth  = 8;
    localparam int c_mem_depth = 16;

    typedef logic [1:0] mux_sel_t;
    localparam mux_sel_t c_mux_shift = 2'b00;
    localparam mux_sel_t c_mux_rf    = 2'b01;
    localparam mux_sel_t c_mux_in    = 2'b10;
    localparam mux_sel_t c_mux_mem   = 2'b11;

    typedef logic [2:0] alu_op_t;
    localparam alu_op_t c_alu_pass = 3'b000;
    localparam alu_op_t c_alu_add  = 3'b001;
    localparam alu_op_t c_alu_sub  = 3'b010;
    localparam alu_op_t c_alu_and  = 3'b011;
    localparam alu_op_t c_alu_or   = 3'b100;
    localparam alu_op_t c_alu_not  = 3'b101;
    localparam alu_op_t c_alu_inc  = 3'b110;
    localparam alu_op_t c_alu_dec  = 3'b111;

    typedef logic [1:0] shift_op_t;
    localparam shift_op_t c_sh_none = 2'b00;
    localparam shift_op_t c_sh_shl  = 2'b01;
    localparam shift_op_t c_sh_shr  = 2'b10;
    localparam shift_op_t c_sh_ror  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cpu_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath_alu
// Description : Combinational 8-bit ALU followed by a post-shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath_alu
    import cpu_datapath_pkg::*;
(
    input  logic [c_data_w-1:0] i_acc,
    input  logic [c_data_w-1:0] i_rf,
    input  alu_op_t             i_alusel,
    input  shift_op_t           i_shiftsel,
    output logic [c_data_w-1:0] o_result
);

    logic [c_data_w-1:0] w_alu;

    always_comb begin
        w_alu = i_acc;
        case (i_alusel)
            c_alu_pass: w_alu = i_acc;
            c_alu_add:  w_alu = i_acc + i_rf;
            c_alu_sub:  w_alu = i_acc - i_rf;
            c_alu_and:  w_alu = i_acc & i_rf;
            c_alu_or:   w_alu = i_acc | i_rf;
            c_alu_not:  w_alu = ~i_acc;
            c_alu_inc:  w_alu = i_acc + 8'd1;
            c_alu_dec:  w_alu = i_acc - 8'd1;
            default:    w_alu = i_acc;
        endcase
    end

    always_comb begin
        o_result = w_alu;
        case (i_shiftsel)
            c_sh_none: o_result = w_alu;
            c_sh_shl:  o_result = {w_alu[c_data_w-2:0], 1'b0};
            c_sh_shr:  o_result = {1'b0, w_alu[c_data_w-1:1]};
            c_sh_ror:  o_result = {w_alu[0], w_alu[c_data_w-1:1]};
            default:   o_result = w_alu;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath
// Description : Accumulator datapath: ACC, 8x8 register file, 16x8 data memory
//               (present only when CPU_DATAPATH_MEM_EN is defined), ALU/shifter
//               and output port register, all driven by controller strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic                clk_dp,
    input  logic                rst_dp,
    input  logic [1:0]          muxsel_dp,
    input  logic [c_data_w-1:0] imm_dp,
    input  logic [c_data_w-1:0] input_dp,
    input  logic                accwr_dp,
    input  logic [2:0]          rfaddr_dp,
    input  logic [3:0]          mmadr_dp,
    input  logic                mmwr_dp,
    input  logic                rfwr_dp,
    input  logic [2:0]          alusel_dp,
    input  logic [1:0]          shiftsel_dp,
    input  logic                outen_dp,
    output logic                zero_dp,
    output logic                positive_dp,
    output logic [c_data_w-1:0] output_dp
);

    logic [c_data_w-1:0] r_acc;
    logic [c_data_w-1:0] r_out;
    logic [c_data_w-1:0] r_rf [c_rf_depth];
    logic [c_data_w-1:0] w_rf_rd;
    logic [c_data_w-1:0] w_mem_rd;
    logic [c_data_w-1:0] w_shift;
    logic [c_data_w-1:0] w_mux;
    logic                w_unused;

    assign w_rf_rd = r_rf[rfaddr_dp];

    cpu_datapath_alu u_alu (
        .i_acc      (r_acc),
        .i_rf       (w_rf_rd),
        .i_alusel   (alusel_dp),
        .i_shiftsel (shiftsel_dp),
        .o_result   (w_shift)
    );

    always_comb begin
        w_mux = w_shift;
        case (muxsel_dp)
            c_mux_shift: w_mux = w_shift;
            c_mux_rf:    w_mux = w_rf_rd;
            c_mux_in:    w_mux = input_dp;
            c_mux_mem:   w_mux = w_mem_rd;
            default:     w_mux = w_shift;
        endcase
    end

    // Every store samples the pre-edge accumulator, so simultaneous strobes are safe.
    always_ff @(posedge clk_dp) begin
        if (rst_dp) begin
            r_acc <= '0;
            r_out <= '0;
            for (int i = 0; i < c_rf_depth; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (accwr_dp) r_acc <= w_mux;
            if (outen_dp) r_out <= r_acc;
            if (rfwr_dp)  r_rf[rfaddr_dp] <= r_acc;
        end
    end

`ifdef CPU_DATAPATH_MEM_EN
    logic [c_data_w-1:0] r_mem [c_mem_depth];

    always_ff @(posedge clk_dp) begin
        if (rst_dp) begin
            for (int i = 0; i < c_mem_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mmwr_dp) begin
            r_mem[mmadr_dp] <= r_acc;
        end
    end

    assign w_mem_rd = r_mem[mmadr_dp];
    assign w_unused = ^imm_dp;
`else
    assign w_mem_rd = '0;
    assign w_unused = ^{imm_dp, mmadr_dp, mmwr_dp};
`endif

    assign zero_dp     = (r_acc == '0);
    assign positive_dp = !r_acc[c_data_w-1] && (r_acc != '0);
    assign output_dp   = r_out;

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Scoreboard bench for cpu_datapath with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;

    logic       clk_dp = 1'b0;
    logic       rst_dp;
    logic [1:0] muxsel_dp;
    logic [7:0] imm_dp;
    logic [7:0] input_dp;
    logic       accwr_dp;
    logic [2:0] rfaddr_dp;
    logic [3:0] mmadr_dp;
    logic       mmwr_dp;
    logic       rfwr_dp;
    logic [2:0] alusel_dp;
    logic [1:0] shiftsel_dp;
    logic       outen_dp;
    logic       zero_dp;
    logic       positive_dp;
    logic [7:0] output_dp;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic       z;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic obs   = 1'b0;
    logic r_obs = 1'b0;

`ifdef CPU_DATAPATH_MEM_EN
    localparam logic [7:0] c_mem_exp = 8'h3C;
`else
    localparam logic [7:0] c_mem_exp = 8'h00;
`endif

    cpu_datapath dut (
        .clk_dp      (clk_dp),
        .rst_dp      (rst_dp),
        .muxsel_dp   (muxsel_dp),
        .imm_dp      (imm_dp),
        .input_dp    (input_dp),
        .accwr_dp    (accwr_dp),
        .rfaddr_dp   (rfaddr_dp),
        .mmadr_dp    (mmadr_dp),
        .mmwr_dp     (mmwr_dp),
        .rfwr_dp     (rfwr_dp),
        .alusel_dp   (alusel_dp),
        .shiftsel_dp (shiftsel_dp),
        .outen_dp    (outen_dp),
        .zero_dp     (zero_dp),
        .positive_dp (positive_dp),
        .output_dp   (output_dp)
    );

    always #5 clk_dp = ~clk_dp;

    always @(posedge clk_dp) r_obs <= obs;

    // Monitor: whenever an observation cycle has just completed, pop and compare.
    always @(negedge clk_dp) begin
        if (r_obs) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: observation with no expected entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_cmp++;
                if (output_dp !== e.out) begin
                    n_err++;
                    $display("FAIL %s.out: got %02h expected %02h", e.name, output_dp, e.out);
                end
                n_cmp++;
                if (zero_dp !== e.z) begin
                    n_err++;
                    $display("FAIL %s.zero: got %b expected %b", e.name, zero_dp, e.z);
                end
                n_cmp++;
                if (positive_dp !== e.p) begin
                    n_err++;
                    $display("FAIL %s.pos: got %b expected %b", e.name, positive_dp, e.p);
                end
            end
        end
    end

    task automatic idle();
        rst_dp = 0; muxsel_dp = 2'b00; imm_dp = 8'h00; input_dp = 8'h00;
        accwr_dp = 0; rfaddr_dp = 3'd0; mmadr_dp = 4'd0; mmwr_dp = 0;
        rfwr_dp = 0; alusel_dp = 3'b000; shiftsel_dp = 2'b00; outen_dp = 0;
    endtask

    task automatic tick();
        @(posedge clk_dp);
        #1;
        idle();
    endtask

    task automatic load(input logic [7:0] v);
        input_dp = v; muxsel_dp = 2'b10; accwr_dp = 1;
        tick();
    endtask

    task automatic rf_to_acc(input logic [2:0] a);
        rfaddr_dp = a; muxsel_dp = 2'b01; accwr_dp = 1;
        tick();
    endtask

    task automatic alu(input logic [2:0] op, input logic [1:0] sh);
        alusel_dp = op; shiftsel_dp = sh; rfaddr_dp = 3'd3;
        muxsel_dp = 2'b00; accwr_dp = 1;
        tick();
    endtask

    // Observation cycle; with strobe set, A is copied to output_dp first.
    task automatic check(input string nm, input logic [7:0] eo,
                         input logic ez, input logic ep, input logic strobe);
        exp_t e;
        e.name = nm; e.out = eo; e.z = ez; e.p = ep;
        q.push_back(e);
        outen_dp = strobe; obs = 1;
        @(posedge clk_dp);
        #1;
        obs = 0;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_dp = 1;
        tick();

        // Dirty every location, then reset while more writes are pending.
        load(8'h5A);
        for (int i = 0; i < 8; i++) begin
            rfaddr_dp = 3'(i); rfwr_dp = 1; tick();
        end
        for (int i = 0; i < 16; i++) begin
            mmadr_dp = 4'(i); mmwr_dp = 1; tick();
        end
        outen_dp = 1; tick();
        rst_dp = 1; input_dp = 8'h77; muxsel_dp = 2'b10; accwr_dp = 1;
        rfwr_dp = 1; mmwr_dp = 1; outen_dp = 1;
        tick();
        check("reset", 8'h00, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            load(8'hAA);
            rf_to_acc(3'(i));
            check($sformatf("rf_rst%0d", i), 8'h00, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 16; i += 5) begin
            load(8'hAA);
            mmadr_dp = 4'(i); muxsel_dp = 2'b11; accwr_dp = 1; tick();
            check($sformatf("mem_rst%0d", i), 8'h00, 1'b1, 1'b0, 1'b1);
        end

        // Load, store, read back
        load(8'h05);
        check("ld05", 8'h05, 1'b0, 1'b1, 1'b1);
        rfaddr_dp = 3'd3; rfwr_dp = 1; tick();
        load(8'h02);
        check("ld02", 8'h02, 1'b0, 1'b1, 1'b1);
        rf_to_acc(3'd3);
        check("rf3", 8'h05, 1'b0, 1'b1, 1'b1);

        // ALU with rf[3]=03
        load(8'h03); rfaddr_dp = 3'd3; rfwr_dp = 1; tick();
        load(8'h05); alu(3'b000, 2'b00); check("pass", 8'h05, 1'b0, 1'b1, 1'b1);
        load(8'h05); alu(3'b001, 2'b00); check("add",  8'h08, 1'b0, 1'b1, 1'b1);
        load(8'h05); alu(3'b010, 2'b00); check("sub",  8'h02, 1'b0, 1'b1, 1'b1);
        load(8'h05); alu(3'b011, 2'b00); check("and",  8'h01, 1'b0, 1'b1, 1'b1);
        load(8'h05); alu(3'b100, 2'b00); check("or",   8'h07, 1'b0, 1'b1, 1'b1);
        load(8'h05); alu(3'b101, 2'b00); check("not",  8'hFA, 1'b0, 1'b0, 1'b1);
        load(8'hFF); alu(3'b110, 2'b00); check("incw", 8'h00, 1'b1, 1'b0, 1'b1);
        load(8'h00); alu(3'b111, 2'b00); check("decw", 8'hFF, 1'b0, 1'b0, 1'b1);
        load(8'h02); alu(3'b010, 2'b00); check("subw", 8'hFF, 1'b0, 1'b0, 1'b1);

        // Shifter
        load(8'h81); alu(3'b000, 2'b00); check("sh00", 8'h81, 1'b0, 1'b0, 1'b1);
        load(8'h81); alu(3'b000, 2'b01); check("shl",  8'h02, 1'b0, 1'b1, 1'b1);
        load(8'h81); alu(3'b000, 2'b10); check("shr",  8'h40, 1'b0, 1'b1, 1'b1);
        load(8'h81); alu(3'b000, 2'b11); check("ror",  8'hC0, 1'b0, 1'b0, 1'b1);
        load(8'h05); alu(3'b001, 2'b01); check("addshl", 8'h10, 1'b0, 1'b1, 1'b1);

        // Memory (or zero source when the memory is not built)
        load(8'h3C); mmadr_dp = 4'hF; mmwr_dp = 1; tick();
        load(8'h00);
        mmadr_dp = 4'hF; muxsel_dp = 2'b11; accwr_dp = 1; tick();
        check("memF", c_mem_exp, (c_mem_exp == 8'h00), (c_mem_exp != 8'h00), 1'b1);

        // Read-during-write on rf returns old contents
        load(8'h44);
        rfaddr_dp = 3'd3; rfwr_dp = 1; muxsel_dp = 2'b01; accwr_dp = 1; tick();
        check("rdw_old", 8'h03, 1'b0, 1'b1, 1'b1);
        rf_to_acc(3'd3);
        check("rdw_new", 8'h44, 1'b0, 1'b1, 1'b1);

        // Simultaneous writes and output hold
        load(8'h11);
        input_dp = 8'h22; muxsel_dp = 2'b10; accwr_dp = 1;
        rfaddr_dp = 3'd0; rfwr_dp = 1; outen_dp = 1; tick();
        check("simul", 8'h11, 1'b0, 1'b1, 1'b0);
        check("hold",  8'h11, 1'b0, 1'b1, 1'b0);
        rf_to_acc(3'd0);
        check("rf0",   8'h11, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk_dp);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
